mem_stage: RTL and testbench

// - Memory-access (M) stage of the 5-stage pipeline: sits between the execute stage (EM_BUS) and writeback (MW_BUS).
// - Holds the EM_BUS payload in a pipeline register. The load data returned by data_sram was already captured

---
 rtl/mem_stage_pkg.sv | 75 +++++++
 rtl/mem_stage_load_align.sv | 48 ++++
 rtl/mem_stage.sv | 129 ++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// mem_stage_pkg
// Bus widths, load-op encodings and packed bus layouts for the memory stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

    localparam int EM_BUS_WID     = 294;
    localparam int MW_BUS_WID     = 262;
    localparam int MD_FOR_BUS_WID = 118;

    // Load encodings, shared with decode and execute; bit0 marks a load,
    // bit2 selects zero-extension.
    localparam logic [3:0] LD_NONE = 4'b0000;
    localparam logic [3:0] LD_B    = 4'b0001;
    localparam logic [3:0] LD_BU   = 4'b0101;
    localparam logic [3:0] LD_H    = 4'b0011;
    localparam logic [3:0] LD_HU   = 4'b0111;
    localparam logic [3:0] LD_W    = 4'b1111;

    // Bit of the pass-through PB field that flags a store instruction.
    localparam int PB_STORE_BIT = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [66:0] pb;
        logic [31:0] pc;
        logic [31:0] rf_wdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [3:0]  res_from_mem;
        logic [31:0] badvaddr;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } em_bus_t;

    // The top spare bits keep the published bus widths; they are always zero.
    typedef struct packed {
        logic [3:0]  rsvd;
        logic [66:0] pb;
        logic [31:0] pc;
        logic [31:0] final_wdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] badvaddr;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } mw_bus_t;

    typedef struct packed {
        logic        rsvd;
        logic        is_load;
        logic [4:0]  dest;
        logic [31:0] final_wdata;
        logic        csr_we;
        logic [13:0] csr_addr;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } md_bus_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
//------------------------------------------------------------------------------
// mem_stage_load_align
// Picks the addressed byte/half of the load word and sign/zero-extends it.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [3:0]  i_res_from_mem,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_zext;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'b00: w_byte = i_rdata[7:0];
            2'b01: w_byte = i_rdata[15:8];
            2'b10: w_byte = i_rdata[23:16];
            2'b11: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_zext = i_res_from_mem[2];

    // Unknown nonzero codes produce zero rather than a partial load.
    always_comb begin
        o_data = 32'h0;
        case (i_res_from_mem)
            LD_B, LD_BU: o_data = w_zext ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            LD_H, LD_HU: o_data = w_zext ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            LD_W:        o_data = i_rdata;
            default:     o_data = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage: holds the EM payload, aligns load data and
// drives the writeback and decode-forwarding buses. Optional MEM_STAT_EN adds
// load/store/exception retire counters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      W_allowin,
    output logic                      M_allowin,
    input  logic                      EM_valid,
    input  logic [EM_BUS_WID-1:0]     EM_BUS,
    output logic                      MW_valid,
    output logic [MW_BUS_WID-1:0]     MW_BUS,
    output logic [MD_FOR_BUS_WID-1:0] MD_for_BUS,
    input  logic                      ex_en,
    output logic                      ex_M
`ifdef MEM_STAT_EN
    ,
    output logic [31:0]               stat_ld_cnt,
    output logic [31:0]               stat_st_cnt,
    output logic [31:0]               stat_ex_cnt
`endif
);

    logic        r_m_valid;
    em_bus_t     r_em_bus;
    logic [31:0] w_load_data;
    logic [31:0] w_final_wdata;
    logic        w_no_ex;
    mw_bus_t     w_mw;
    md_bus_t     w_md;

    // The stage always completes in one cycle, so only writeback can stall it.
    assign M_allowin = !r_m_valid || W_allowin;
    assign MW_valid  = r_m_valid;
    assign ex_M      = r_m_valid && r_em_bus.ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_em_bus  <= '0;
        end else if (ex_en) begin
            r_m_valid <= 1'b0;
            r_em_bus  <= '0;
        end else if (M_allowin) begin
            r_m_valid <= EM_valid;
            if (EM_valid) begin
                r_em_bus <= em_bus_t'(EM_BUS);
            end
        end
    end

    mem_stage_load_align u_load_align (
        .i_rdata        (r_em_bus.rdata),
        .i_addr         (r_em_bus.rf_wdata[1:0]),
        .i_res_from_mem (r_em_bus.res_from_mem),
        .o_data         (w_load_data)
    );

    assign w_final_wdata = (r_em_bus.res_from_mem == LD_NONE) ? r_em_bus.rf_wdata : w_load_data;
    assign w_no_ex       = !r_em_bus.ex;

    always_comb begin
        w_mw             = '0;
        w_mw.pb          = r_em_bus.pb;
        w_mw.pc          = r_em_bus.pc;
        w_mw.final_wdata = w_final_wdata;
        w_mw.gr_we       = r_em_bus.gr_we && w_no_ex;
        w_mw.dest        = r_em_bus.dest;
        w_mw.badvaddr    = r_em_bus.badvaddr;
        w_mw.ex          = r_em_bus.ex;
        w_mw.ecode       = r_em_bus.ecode;
        w_mw.esubcode    = r_em_bus.esubcode;
        w_mw.csr_addr    = r_em_bus.csr_addr;
        w_mw.csr_we      = r_em_bus.csr_we && w_no_ex;
        w_mw.csr_wmask   = r_em_bus.csr_wmask;
        w_mw.csr_wdata   = r_em_bus.csr_wdata;
    end

    // Decode sees a register/CSR write only from a live, non-excepting instruction.
    always_comb begin
        w_md             = '0;
        w_md.is_load     = (|r_em_bus.res_from_mem) && r_m_valid;
        w_md.dest        = r_em_bus.dest & {5{r_m_valid && r_em_bus.gr_we && w_no_ex}};
        w_md.final_wdata = w_final_wdata;
        w_md.csr_we      = r_em_bus.csr_we && r_m_valid && w_no_ex;
        w_md.csr_addr    = r_em_bus.csr_addr;
        w_md.csr_wmask   = r_em_bus.csr_wmask;
        w_md.csr_wdata   = r_em_bus.csr_wdata;
    end

    assign MW_BUS     = w_mw;
    assign MD_for_BUS = w_md;

`ifdef MEM_STAT_EN
    logic        w_leave;
    logic [31:0] r_stat_ld;
    logic [31:0] r_stat_st;
    logic [31:0] r_stat_ex;

    assign w_leave = r_m_valid && W_allowin && !ex_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ld <= 32'h0;
            r_stat_st <= 32'h0;
            r_stat_ex <= 32'h0;
        end else if (w_leave) begin
            if (w_md.is_load)                r_stat_ld <= r_stat_ld + 32'h1;
            if (r_em_bus.pb[PB_STORE_BIT])   r_stat_st <= r_stat_st + 32'h1;
            if (r_em_bus.ex)                 r_stat_ex <= r_stat_ex + 32'h1;
        end
    end

    assign stat_ld_cnt = r_stat_ld;
    assign stat_st_cnt = r_stat_st;
    assign stat_ex_cnt = r_stat_ex;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// tb_mem_stage
// Scoreboard bench for mem_stage: loads, ALU pass-through, exceptions,
// back-pressure and flush.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      W_allowin;
    logic                      M_allowin;
    logic                      EM_valid;
    logic [EM_BUS_WID-1:0]     EM_BUS;
    logic                      MW_valid;
    logic [MW_BUS_WID-1:0]     MW_BUS;
    logic [MD_FOR_BUS_WID-1:0] MD_for_BUS;
    logic                      ex_en;
    logic                      ex_M;
`ifdef MEM_STAT_EN
    logic [31:0] stat_ld_cnt, stat_st_cnt, stat_ex_cnt;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .W_allowin  (W_allowin),
        .M_allowin  (M_allowin),
        .EM_valid   (EM_valid),
        .EM_BUS     (EM_BUS),
        .MW_valid   (MW_valid),
        .MW_BUS     (MW_BUS),
        .MD_for_BUS (MD_for_BUS),
        .ex_en      (ex_en),
        .ex_M       (ex_M)
`ifdef MEM_STAT_EN
        ,
        .stat_ld_cnt(stat_ld_cnt),
        .stat_st_cnt(stat_st_cnt),
        .stat_ex_cnt(stat_ex_cnt)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic [66:0] pb;
        logic [31:0] pc;
        logic [31:0] rf;
        logic        gr_we;
        logic [4:0]  dest;
        logic [3:0]  op;
        logic [31:0] bad;
        logic        ex;
        logic [7:0]  ecode;
        logic        esub;
        logic [13:0] caddr;
        logic        cwe;
        logic [31:0] wmask;
        logic [31:0] wdata;
        logic [31:0] fw;
    } txn_t;

    txn_t sb[$];
    txn_t cur;
    logic m_valid;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic txn_t mk(input logic [31:0] rd, input logic [31:0] rf, input logic [3:0] op,
                                input logic [31:0] fw, input logic ex, input logic gw, input logic [4:0] dest);
        txn_t t;
        t.rdata = rd;   t.rf = rf;   t.op = op;   t.fw = fw;
        t.ex = ex;      t.gr_we = gw; t.dest = dest;
        t.pb    = {$urandom, $urandom, 3'($urandom)};
        t.pc    = $urandom;
        t.bad   = $urandom;
        t.ecode = ex ? 8'h09 : 8'($urandom);
        t.esub  = 1'($urandom);
        t.caddr = 14'($urandom);
        t.cwe   = 1'b1;
        t.wmask = $urandom;
        t.wdata = $urandom;
        return t;
    endfunction

    function automatic logic [EM_BUS_WID-1:0] em_of(input txn_t t);
        return {t.rdata, t.pb, t.pc, t.rf, t.gr_we, t.dest, t.op, t.bad, t.ex, t.ecode,
                t.esub, t.caddr, t.cwe, t.wmask, t.wdata};
    endfunction

    function automatic logic [MW_BUS_WID-1:0] mw_of(input txn_t t);
        return {4'b0, t.pb, t.pc, t.fw, t.gr_we & ~t.ex, t.dest, t.bad, t.ex, t.ecode,
                t.esub, t.caddr, t.cwe & ~t.ex, t.wmask, t.wdata};
    endfunction

    function automatic logic [MD_FOR_BUS_WID-1:0] md_of(input txn_t t);
        return {1'b0, t.op != 4'b0, t.dest & {5{t.gr_we & ~t.ex}}, t.fw, t.cwe & ~t.ex,
                t.caddr, t.wmask, t.wdata};
    endfunction

    task automatic drive(input txn_t t);
        cur      = t;
        EM_valid = 1'b1;
        EM_BUS   = em_of(t);
    endtask

    // Called at a negedge with inputs settled: advances the model one cycle,
    // then compares the DUT at the following negedge.
    task automatic step(input string tag);
        logic allow;
        allow = !m_valid || W_allowin;
        if (m_valid && (ex_en || W_allowin)) void'(sb.pop_front());
        if (ex_en) m_valid = 1'b0;
        else if (allow) begin
            m_valid = EM_valid;
            if (EM_valid) sb.push_back(cur);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 264'(MW_valid), 264'(m_valid));
        check({tag, "_allowin"}, 264'(M_allowin), 264'(!m_valid || W_allowin));
        if (m_valid && sb.size() > 0) begin
            check({tag, "_mw"}, 264'(MW_BUS), 264'(mw_of(sb[0])));
            check({tag, "_md"}, 264'(MD_for_BUS), 264'(md_of(sb[0])));
            check({tag, "_exM"}, 264'(ex_M), 264'(sb[0].ex));
        end else begin
            check({tag, "_exM_idle"}, 264'(ex_M), 264'(0));
            check({tag, "_md_idle"}, 264'({MD_for_BUS[116:111], MD_for_BUS[78]}), 264'(0));
        end
    endtask

    txn_t vec[$];

    initial begin
        rst = 1'b1; W_allowin = 1'b1; EM_valid = 1'b0; EM_BUS = '0; ex_en = 1'b0;
        m_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 264'(MW_valid), 264'(0));
        check("rst_exM", 264'(ex_M), 264'(0));
        check("rst_mw", 264'(MW_BUS), 264'(0));
        check("rst_md", 264'(MD_for_BUS), 264'(0));
        check("rst_allowin", 264'(M_allowin), 264'(1));
        rst = 1'b0;

        vec.push_back(mk(32'h80FF_7F01, 32'h0000_1003, LD_B,  32'hFFFF_FF80, 1'b0, 1'b1, 5'd3));
        vec.push_back(mk(32'h80FF_7F01, 32'h0000_1001, LD_B,  32'h0000_007F, 1'b0, 1'b1, 5'd4));
        vec.push_back(mk(32'h80FF_7F01, 32'h0000_1002, LD_B,  32'hFFFF_FFFF, 1'b0, 1'b1, 5'd6));
        vec.push_back(mk(32'h80FF_7F01, 32'h0000_1003, LD_BU, 32'h0000_0080, 1'b0, 1'b1, 5'd7));
        vec.push_back(mk(32'h8001_F00F, 32'h0000_2002, LD_HU, 32'h0000_8001, 1'b0, 1'b1, 5'd8));
        vec.push_back(mk(32'h8001_F00F, 32'h0000_2000, LD_H,  32'hFFFF_F00F, 1'b0, 1'b1, 5'd9));
        vec.push_back(mk(32'hDEAD_BEEF, 32'h0000_3000, LD_W,  32'hDEAD_BEEF, 1'b0, 1'b1, 5'd10));
        vec.push_back(mk(32'hAAAA_5555, 32'h1234_5678, LD_NONE, 32'h1234_5678, 1'b0, 1'b1, 5'd11));
        vec.push_back(mk(32'hAAAA_5555, 32'h1234_5678, 4'b0010, 32'h0000_0000, 1'b0, 1'b0, 5'd12));
        foreach (vec[i]) begin
            drive(vec[i]);
            step($sformatf("ld%0d", i));
        end
        EM_valid = 1'b0;
        step("drain");
        step("idle");

        // Excepting instruction: writes suppressed, ex_M for one cycle only.
        drive(mk(32'h0, 32'h0000_0040, LD_NONE, 32'h0000_0040, 1'b1, 1'b1, 5'd5));
        step("ex");
        EM_valid = 1'b0;
        step("ex_after");

        // Back-pressure: A held for several cycles while B waits upstream.
        W_allowin = 1'b0;
        drive(mk(32'h1111_2222, 32'h0000_0000, LD_W, 32'h1111_2222, 1'b0, 1'b1, 5'd13));
        step("bp_a");
        drive(mk(32'h3333_4444, 32'h5555_6666, LD_NONE, 32'h5555_6666, 1'b0, 1'b1, 5'd14));
        for (int i = 0; i < 3; i++) step($sformatf("bp_hold%0d", i));
        W_allowin = 1'b1;
        step("bp_b");
        EM_valid = 1'b0;
        step("bp_drain");

        // Flush beats a simultaneous accept, with and without a resident.
        drive(mk(32'h0, 32'h7777_0000, LD_NONE, 32'h7777_0000, 1'b0, 1'b1, 5'd15));
        ex_en = 1'b1;
        step("flush_empty");
        ex_en = 1'b0;
        step("flush_resident_load");
        drive(mk(32'h0, 32'h8888_0000, LD_NONE, 32'h8888_0000, 1'b0, 1'b1, 5'd16));
        ex_en = 1'b1;
        step("flush_resident");
        ex_en = 1'b0; EM_valid = 1'b0;
        step("flush_after");
        step("flush_idle");

        check("sb_empty", 264'(sb.size()), 264'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
